// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Two-requester arbiter in front of a single-ported memory. Grants are
//   combinational in the request cycle. m0 has priority, but m1 is forced
//   through after STARVE_LIMIT consecutive waiting cycles. A requester may
//   lock the port for an atomic sequence of up to LOCK_MAX grants. Read data
//   returns one cycle after the grant and is steered back to its owner.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   mN_req_i / mN_lock_i    request and keep-ownership from requester N
//   mN_addr_i/we_i/be_i     access address, write flag, byte enables
//   mN_wdata_i / is_cap_i   write data (top bit is the capability tag), cap access
//   mN_gnt_o                access accepted this cycle
//   mN_rvalid_o/rdata_o     read response for requester N
//   mem_*_o                 memory request of the granted requester (zero when idle)
//   mem_rdata_i             memory read data, one cycle after a read strobe
module dram_port_arbiter #(
  parameter int DATA_WIDTH   = 33,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_lock_i,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic                  m0_is_cap_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_lock_i,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic                  m1_is_cap_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic                  mem_is_cap_o,
  output logic [31:0]           mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // lock_cnt value before the grant that completes a full locked sequence
  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic       gnt0, gnt1;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  // Grant decode (output process)
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          if (starve_q == STARVE_MAX) gnt1 = 1'b1;
          else                        gnt0 = 1'b1;
        end else begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i;
        end
      end
      // The owner of a lock is the only candidate; the other side waits
      // even if it is starving.
      LOCK0:   gnt0 = m0_req_i;
      LOCK1:   gnt1 = m1_req_i;
      default: ;
    endcase
  end

  // Next-state process
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 && m0_lock_i) begin
          state_d    = LOCK0;
          lock_cnt_d = 8'd1;
        end else if (gnt1 && m1_lock_i) begin
          state_d    = LOCK1;
          lock_cnt_d = 8'd1;
        end
      end
      LOCK0: begin
        if (!m0_req_i) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (!m0_lock_i || lock_cnt_q == LOCK_LAST) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      LOCK1: begin
        if (!m1_req_i) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (!m1_lock_i || lock_cnt_q == LOCK_LAST) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase

    // m1 waiting time; keeps counting while a lock holds it off
    if (!m1_req_i || gnt1)          starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
    else                            starve_d = starve_q;

    // Response ownership is tracked apart from the FSM so a read in the
    // last locked grant still returns to its requester.
    rvalid0_d = gnt0 && !m0_we_i;
    rvalid1_d = gnt1 && !m1_we_i;
  end

  // Memory request mux
  always_comb begin
    mem_we_o     = 1'b0;
    mem_is_cap_o = 1'b0;
    mem_addr_o   = '0;
    mem_be_o     = '0;
    mem_wdata_o  = '0;
    if (gnt0) begin
      mem_we_o     = m0_we_i;
      mem_is_cap_o = m0_is_cap_i;
      mem_addr_o   = m0_addr_i;
      mem_be_o     = m0_be_i;
      mem_wdata_o  = m0_wdata_i;
    end else if (gnt1) begin
      mem_we_o     = m1_we_i;
      mem_is_cap_o = m1_is_cap_i;
      mem_addr_o   = m1_addr_i;
      mem_be_o     = m1_be_i;
      mem_wdata_o  = m1_wdata_i;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign mem_en_o    = gnt0 | gnt1;
  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m0_rdata_o  = rvalid0_q ? mem_rdata_i : '0;
  assign m1_rdata_o  = rvalid1_q ? mem_rdata_i : '0;

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 33: data/rdata width; legal values 33 or 65, where bit DATA_WIDTH-1 is the capability tag.
REQ-002 Parameter STARVE_LIMIT, default 4: number of consecutive cycles m1 may wait before it is force-granted over m0; range 1..15.
REQ-003 Parameter LOCK_MAX, default 8: maximum number of grants in one locked sequence; range 2..255.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 mN_req_i  input  1  access request from requester N, N in {0,1}.
REQ-007 mN_lock_i  input  1  keep ownership after this access (atomic sequence).
REQ-008 mN_addr_i  input  32  byte address.
REQ-009 mN_we_i  input  1  1 = write, 0 = read.
REQ-010 mN_be_i  input  4  byte enables.
REQ-011 mN_wdata_i  input  DATA_WIDTH  write data.
REQ-012 mN_is_cap_i  input  1  capability-width access.
REQ-013 mN_gnt_o  output  1  access accepted this cycle.
REQ-014 mN_rvalid_o  output  1  read data valid for requester N.
REQ-015 mN_rdata_o  output  DATA_WIDTH  read data.
REQ-016 mem_en_o, mem_we_o, mem_is_cap_o  output  1 each  memory strobe, write, and capability controls.
REQ-017 mem_addr_o  output  32  memory address.
REQ-018 mem_be_o  output  4  memory byte enables.
REQ-019 mem_wdata_o  output  DATA_WIDTH  memory write data.
REQ-020 mem_rdata_i  input  DATA_WIDTH  memory read data, valid one cycle after mem_en_o with mem_we_o=0.

Function
REQ-021 Grant is combinational in the request cycle; at most one mN_gnt_o is high per cycle; mem_en_o = m0_gnt_o | m1_gnt_o.
REQ-022 mem_addr/we/be/wdata/is_cap_o carry the granted requester's inputs and are all-zero when there is no grant.
REQ-023 The FSM has three states: IDLE, LOCK0, LOCK1.
REQ-024 IDLE arbitration: m0 wins if both request, unless starve_cnt == STARVE_LIMIT, in which case m1 wins; a sole requester always wins.
REQ-025 starve_cnt (4 bits): cleared when m1 is granted or m1_req_i=0; otherwise incremented when m1_req_i=1 and m1 is not granted; saturates at STARVE_LIMIT.
REQ-026 In IDLE, a grant to N with mN_lock_i=1 moves the FSM to LOCKN and loads lock_cnt=1.
REQ-027 In LOCKN, only N may be granted, and only if mN_req_i=1; the other requester is held off regardless of starve_cnt.
REQ-028 In LOCKN, on each granted cycle lock_cnt increments.
REQ-029 In LOCKN, the FSM returns to IDLE after a granted access with mN_lock_i=0.
REQ-030 In LOCKN, the FSM returns to IDLE after the granted access that makes lock_cnt equal LOCK_MAX (forced release).
REQ-031 In LOCKN, the FSM returns to IDLE on any cycle with mN_req_i=0; no grant is issued in that cycle.
REQ-032 When a lock is released, normal IDLE arbitration, including starvation forcing, resumes in the next cycle.
REQ-033 A granted read (we=0) to N sets mN_rvalid_o=1 in the following cycle with mN_rdata_o = mem_rdata_i.
REQ-034 mN_rdata_o is all-zero whenever mN_rvalid_o=0.
REQ-035 Writes produce no rvalid.
REQ-036 Back-to-back reads produce back-to-back rvalid pulses.
REQ-037 The response-owner register is independent of the FSM, so a read in the final locked grant still returns its data to its owner.

Reset
REQ-038 While rst_i=1: FSM=IDLE, starve_cnt=0, lock_cnt=0, and both rvalid registers are 0.
REQ-039 With no requests, all outputs are 0.
REQ-040 Asserting rst_i mid-lock or with a read in flight drops the pending rvalid and aborts the lock; no response is delivered after reset releases.

Verification
REQ-041 m0 and m1 both read every cycle, STARVE_LIMIT=4 -> m0 granted 4 cycles, m1 granted in cycle 5, then m0; each rvalid follows its grant by 1 cycle with matching data.
REQ-042 m1 lock=1 for 3 writes then lock=0 on the 4th, m0 requesting throughout -> m0_gnt_o=0 for those 4 cycles, m0 granted in the next cycle.
REQ-043 m0 lock held high continuously, LOCK_MAX=8, m1 requesting -> exactly 8 m0 grants, then m1 granted (starve_cnt saturated).
REQ-044 Single m1 read at address 0x0000_1004 with is_cap=1 -> mem_addr_o=0x0000_1004, mem_is_cap_o=1 in the same cycle; m1_rvalid_o=1 with the memory data one cycle later; m0 outputs stay 0.
REQ-045 rst_i pulsed the cycle after an m0 read grant inside LOCK0 -> m0_rvalid_o never asserts; after release, FSM=IDLE and a fresh m1 request is granted immediately.
